// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: FSM encoding and
// default reset vector / instruction size.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h8000_0000;
    localparam int unsigned PC_INST_BYTES   = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-fetch request bus between the PC generator and instruction memory.
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              if_gnt;

    modport master (output pc, output ce, input if_gnt);
    modport slave  (input pc, input ce, output if_gnt);
endinterface

// File: rtl/pc_redirect_buf.sv
// Redirect selection for the PC generator: 1-deep pending branch target,
// flush/branch/pending priority mux and target alignment check.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned INST_BYTES = PC_INST_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              advance,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              pending,
    output logic              misalign
);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] raw_target;

    // A fresh branch beats the buffered one; flush beats both.
    always_comb begin
        raw_target = pend_target;
        if (flush)
            raw_target = new_pc;
        else if (branch_flag)
            raw_target = branch_target;
    end

    assign redirect    = active & (flush | (advance & (branch_flag | pend_valid)));
    assign redirect_pc = raw_target & ~LOW_MASK;
    assign pending     = pend_valid;

    // Any advance consumes the buffer: either applied now or superseded by a new branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
            misalign    <= 1'b0;
        end else begin
            misalign <= redirect & (|(raw_target & LOW_MASK));
            if (active & (flush | advance)) begin
                pend_valid <= 1'b0;
            end else if (active & branch_flag) begin
                pend_valid  <= 1'b1;
                pend_target <= branch_target;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter generator: boot sequencing, halt, stall,
// flush and branch redirects with a 1-deep pending branch buffer.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
    parameter int unsigned       INST_BYTES   = PC_INST_BYTES,
    parameter int unsigned       STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               halt_i,
    pc_gen_if.master           fetch,
    output logic               branch_pending_o,
    output logic               misalign_o
);
    pc_state_e         state, state_next;
    logic [ADDR_W-1:0] pc_q, pc_next;
    logic              advance;
    logic              active;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              unused_stall;

    assign unused_stall = ^stall[STALL_W-1:0];
    assign advance      = (state == ST_RUN) & ~stall[0] & fetch.if_gnt;
    assign active       = (state == ST_RUN) | (state == ST_HALT);

    pc_redirect_buf #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES)
    ) u_redirect (
        .clk           (clk),
        .rst           (rst),
        .active        (active),
        .advance       (advance),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag   (branch_flag_i),
        .branch_target (branch_target_address_i),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .pending       (branch_pending_o),
        .misalign      (misalign_o)
    );

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        case (state)
            ST_RESET: state_next = ST_BOOT;
            ST_BOOT: begin
                state_next = ST_RUN;
                pc_next    = RESET_VECTOR;
            end
            ST_RUN, ST_HALT: begin
                if (state == ST_RUN && halt_i && !flush)
                    state_next = ST_HALT;
                else if (state == ST_HALT && !halt_i)
                    state_next = ST_RUN;
                if (redirect)
                    pc_next = redirect_pc;
                else if (advance)
                    pc_next = pc_q + ADDR_W'(INST_BYTES);
            end
            default: state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RESET;
            pc_q  <= RESET_VECTOR;
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
        end
    end

    assign fetch.pc = pc_q;
    assign fetch.ce = (state == ST_RUN);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against a 32-bit and a 16-bit instance.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        halt;
    logic        gnt;
    logic        pend_a, mis_a, pend_b, mis_b;

    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32)) fa ();
    pc_gen_if #(.ADDR_W(16)) fb ();
    assign fa.if_gnt = gnt;
    assign fb.if_gnt = gnt;

    pc_gen #(.ADDR_W(32)) dut_a (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag),
        .branch_target_address_i (branch_target),
        .halt_i                  (halt),
        .fetch                   (fa),
        .branch_pending_o        (pend_a),
        .misalign_o              (mis_a)
    );

    pc_gen #(.ADDR_W(16), .RESET_VECTOR(16'hFFF8)) dut_b (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc[15:0]),
        .branch_flag_i           (branch_flag),
        .branch_target_address_i (branch_target[15:0]),
        .halt_i                  (halt),
        .fetch                   (fb),
        .branch_pending_o        (pend_b),
        .misalign_o              (mis_b)
    );

    typedef struct {
        int          cyc;
        bit          sel;
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    bit   sel   = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    exp_t        mon_e;
    logic [31:0] apc;
    logic        ace, apend, amis;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.sel) begin
                apc = {16'h0000, fb.pc}; ace = fb.ce; apend = pend_b; amis = mis_b;
            end else begin
                apc = fa.pc; ace = fa.ce; apend = pend_a; amis = mis_a;
            end
            total++;
            if (mon_e.cyc != cyc || apc !== mon_e.pc || ace !== mon_e.ce ||
                apend !== mon_e.pend || amis !== mon_e.mis) begin
                bad++;
                $display("FAIL %s cyc=%0d: got pc=%h ce=%b pend=%b mis=%b, want pc=%h ce=%b pend=%b mis=%b",
                         mon_e.name, cyc, apc, ace, apend, amis,
                         mon_e.pc, mon_e.ce, mon_e.pend, mon_e.mis);
            end
        end
    end

    task automatic step(input logic r, input logic st, input logic fl, input logic [31:0] npc,
                        input logic br, input logic [31:0] bt, input logic hl, input logic gn,
                        input logic [31:0] xpc, input logic xce, input logic xpend,
                        input logic xmis, input string nm);
        exp_t e;
        rst           = r;
        stall         = {5'($urandom), st};
        flush         = fl;
        new_pc        = npc;
        branch_flag   = br;
        branch_target = bt;
        halt          = hl;
        gnt           = gn;
        e.cyc  = cyc + 1;
        e.sel  = sel;
        e.pc   = xpc;
        e.ce   = xce;
        e.pend = xpend;
        e.mis  = xmis;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] xpc, input string nm);
        step(1, 0, 0, 0, 0, 0, 0, 1, xpc, 1, 0, 0, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 0; stall = 0; flush = 0; new_pc = 0; branch_flag = 0;
        branch_target = 0; halt = 0; gnt = 1;
        @(posedge clk);
        #1;

        // Reset and boot sequence
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0000, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0000, 0, 0, 0, "boot");
        run(32'h8000_0000, "run0");
        run(32'h8000_0004, "run1");
        run(32'h8000_0008, "run2");

        // Branch under stall is buffered, then applied on release
        step(1, 1, 0, 0, 1, 32'h8000_1000, 0, 1, 32'h8000_0008, 1, 1, 0, "br_stall");
        step(1, 1, 0, 0, 0, 0, 0, 1, 32'h8000_0008, 1, 1, 0, "br_hold");
        run(32'h8000_1000, "br_apply");
        run(32'h8000_1004, "br_next");

        // Newer branch overwrites the buffered one
        step(1, 1, 0, 0, 1, 32'h8000_1000, 0, 1, 32'h8000_1004, 1, 1, 0, "br2_first");
        step(1, 1, 0, 0, 1, 32'h8000_2000, 0, 1, 32'h8000_1004, 1, 1, 0, "br2_second");
        run(32'h8000_2000, "br2_apply");
        run(32'h8000_2004, "br2_next");

        // Flush beats pending branch, new branch and stall
        step(1, 1, 0, 0, 1, 32'h8000_3000, 0, 1, 32'h8000_2004, 1, 1, 0, "fl_setup");
        step(1, 1, 1, 32'h8000_0180, 1, 32'h8000_4000, 0, 1, 32'h8000_0180, 1, 0, 0, "flush");
        run(32'h8000_0184, "flush_next");

        // Misaligned redirect targets
        step(1, 0, 0, 0, 1, 32'h8000_0102, 0, 1, 32'h8000_0100, 1, 0, 1, "mis_branch");
        run(32'h8000_0104, "mis_clear");
        step(1, 0, 1, 32'h8000_0203, 0, 0, 0, 1, 32'h8000_0200, 1, 0, 1, "mis_flush");
        run(32'h8000_0204, "mis_clear2");

        // Halt: flush blocks entry, branch buffered while halted, resume keeps pc
        step(1, 0, 1, 32'h8000_0300, 0, 0, 1, 0, 32'h8000_0300, 1, 0, 0, "halt_flush");
        step(1, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0300, 0, 0, 0, "halt_enter");
        step(1, 0, 0, 0, 1, 32'h8000_0400, 1, 1, 32'h8000_0300, 0, 1, 0, "halt_branch");
        step(1, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0300, 1, 1, 0, "halt_exit");
        run(32'h8000_0400, "halt_apply");
        run(32'h8000_0404, "halt_next");

        // Reset mid-operation drops pending branch and flush
        step(1, 1, 0, 0, 1, 32'h8000_0500, 0, 1, 32'h8000_0404, 1, 1, 0, "rst_setup");
        step(0, 0, 1, 32'h8000_0600, 0, 0, 0, 1, 32'h8000_0000, 0, 0, 0, "rst_mid");

        // 16-bit instance: wrap, grant stall, halt
        sel = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_FFF8, 0, 0, 0, "w_boot");
        run(32'h0000_FFF8, "w_run0");
        run(32'h0000_FFFC, "w_run1");
        run(32'h0000_0000, "w_wrap");
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0, "w_nognt0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0, "w_nognt1");
        run(32'h0000_0004, "w_gnt");
        step(1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0008, 0, 0, 0, "w_halt");
        step(1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0008, 0, 0, 0, "w_halt_hold0");
        step(1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0008, 0, 0, 0, "w_halt_hold1");
        step(1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0008, 1, 0, 0, "w_resume");
        run(32'h0000_000C, "w_next");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
